div_uart_ctrl: RTL and testbench

Command sequencer between the UART FIFOs and the sequential divider `rdd`. It pops a dividend byte and then a divisor byte from the UART receive FIFO, and drives `x`, `y` and a one-cycle `start` into the divider. It waits for the divider's `done` tick, then pushes the quotient and the remainder into the UART transmit FIFO. It also traps divide-by-zero and divider hang, answering each with fixed error bytes.

---
 rtl/div_uart_pkg.sv | 18 +
 rtl/div_uart_ctrl.sv | 127 ++++++++++++
 tb/tb_div_uart_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_uart_pkg.sv
// Shared types and constants for the UART-to-divider command sequencer.
// State enumeration, error reply codes and the default hang timeout.
package div_uart_pkg;

  typedef enum logic [2:0] {
    GET_X,
    GET_Y,
    START,
    WAIT,
    SEND_Q,
    SEND_R
  } state_t;

  localparam logic [7:0] DIV0_Q    = 8'hFF;
  localparam logic [7:0] HANG_CODE = 8'hEE;
  localparam int         DEF_TIMEOUT = 1024;

endpackage

// File: rtl/div_uart_ctrl.sv
// Sequencer: pops x and y from the UART RX FIFO, runs the divider,
// and pushes quotient then remainder; traps divide-by-zero and hang.
module div_uart_ctrl
  import div_uart_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_empty,
  output logic             rd_uart,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             start,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] remainder,
  input  logic             done,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             w_y_zero;
  logic             w_expire;

  assign w_y_zero = (r_y == '0);
  assign w_expire = (r_cnt == LAST);

  always_comb begin
    w_next  = r_state;
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    start   = 1'b0;
    unique case (r_state)
      GET_X: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          w_next  = GET_Y;
        end
      end
      GET_Y: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          w_next  = START;
        end
      end
      START: begin
        start  = !w_y_zero;
        w_next = w_y_zero ? SEND_Q : WAIT;
      end
      WAIT: begin
        if (done || w_expire)
          w_next = SEND_Q;
      end
      SEND_Q: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_next  = SEND_R;
        end
      end
      SEND_R: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_next  = GET_X;
        end
      end
      default: w_next = GET_X;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= GET_X;
      r_x     <= '0;
      r_y     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        GET_X: if (rd_uart) r_x <= rx_data;
        GET_Y: if (rd_uart) r_y <= rx_data;
        START: begin
          if (w_y_zero) begin
            r_q <= '1;
            r_r <= r_x;
          end else begin
            r_cnt <= '0;
          end
        end
        WAIT: begin
          // done takes priority over an expiring timeout
          if (done) begin
            r_q <= quotient;
            r_r <= remainder;
          end else if (w_expire) begin
            r_q <= WIDTH'(HANG_CODE);
            r_r <= WIDTH'(HANG_CODE);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data = (r_state == SEND_R) ? r_r : r_q;
  assign x       = r_x;
  assign y       = r_y;
  assign busy    = (r_state != GET_X);

endmodule

// File: tb/tb_div_uart_ctrl.sv
// Bench for div_uart_ctrl: FIFO and divider models around the DUT,
// results checked against a per-command reference of the reply bytes.
module tb_div_uart_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] x;
  logic [7:0] y;
  logic       start;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       done;
  logic       busy;

  div_uart_ctrl #(.WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .tx_data(tx_data), .tx_full(tx_full), .wr_uart(wr_uart),
    .x(x), .y(y), .start(start),
    .quotient(quotient), .remainder(remainder), .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int         tx_cyc[$];
  int         rd_cyc[$];
  int         lat_q[$];
  bit         rx_hold_rand = 0;
  bit         tx_full_rand = 0;
  int         full_after_done = 0;
  int         full_cnt = 0;
  int         div_lat = 0;
  bit         div_pend = 0;
  int         div_left = 0;
  logic [7:0] div_x = 0;
  logic [7:0] div_y = 0;
  bit         stray_done = 0;
  int         starts = 0;
  int         start_cyc = 0;
  int         done_cyc = 0;
  int         proto_err = 0;
  int         cyc = 0;

  // Environment: inputs change on negedge, outputs observed 1ns before posedge
  initial begin
    rx_empty = 1'b1; rx_data = '0; tx_full = 1'b0;
    done = 1'b0; quotient = '0; remainder = '0;
    forever begin
      @(negedge clk);
      cyc++;
      tx_full = (full_cnt > 0) ||
                (tx_full_rand && $urandom_range(0, 2) == 0);
      if (full_cnt > 0) full_cnt--;
      done = 1'b0;
      quotient = 8'($urandom);
      remainder = 8'($urandom);
      if (div_pend) begin
        div_left--;
        if (div_left == 0) begin
          div_pend = 0;
          done = 1'b1;
          quotient = (div_y == 0) ? 8'hFF : div_x / div_y;
          remainder = (div_y == 0) ? div_x : div_x % div_y;
          done_cyc = cyc;
          full_cnt = full_after_done;
        end
      end
      if (stray_done) begin
        done = 1'b1;
        stray_done = 0;
      end
      rx_empty = (rxq.size() == 0) ||
                 (rx_hold_rand && $urandom_range(0, 1) == 0);
      rx_data = (rxq.size() != 0) ? rxq[0] : 8'($urandom);
      #4;
      if (reset) begin
        if (div_pend && (x != div_x || y != div_y)) proto_err++;
        if (rd_uart) begin
          if (rx_empty) proto_err++;
          else begin
            void'(rxq.pop_front());
            rd_cyc.push_back(cyc);
          end
        end
        if (wr_uart) begin
          if (tx_full) proto_err++;
          txq.push_back(tx_data);
          tx_cyc.push_back(cyc);
        end
        if (start) begin
          int l;
          starts++;
          start_cyc = cyc;
          div_x = x;
          div_y = y;
          l = (lat_q.size() != 0) ? lat_q.pop_front() : div_lat;
          div_pend = (l > 0);
          div_left = l;
        end
      end
    end
  end

  function automatic void ref_reply(input logic [7:0] a, input logic [7:0] b,
                                    input int lat,
                                    output logic [7:0] q, output logic [7:0] r);
    if (b == 0) begin
      q = 8'hFF; r = a;
    end else if (lat == 0 || lat > TO) begin
      q = 8'hEE; r = 8'hEE;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  task automatic wait_tx(input int n, output bit ok);
    int k = 0;
    while (txq.size() < n && k < 4000) begin
      @(negedge clk);
      k++;
    end
    ok = (txq.size() >= n);
  endtask

  task automatic clear_env();
    repeat (3) @(negedge clk);
    txq.delete(); tx_cyc.delete(); rd_cyc.delete(); lat_q.delete();
    starts = 0;
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b,
                         input string tag);
    logic [7:0] eq, er;
    bit ok;
    ref_reply(a, b, div_lat, eq, er);
    rxq.push_back(a);
    rxq.push_back(b);
    wait_tx(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: got %0d bytes, need 2", tag, txq.size());
    end else begin
      checks++;
      if (txq[0] !== eq) begin
        errors++;
        $display("FAIL %s quotient: got %02h, need %02h", tag, txq[0], eq);
      end
      checks++;
      if (txq[1] !== er) begin
        errors++;
        $display("FAIL %s remainder: got %02h, need %02h", tag, txq[1], er);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({rd_uart, wr_uart, start, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b, need 0000",
               {rd_uart, wr_uart, start, busy});
    end
    checks++;
    if ({x, y, tx_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got %06h, need 000000", {x, y, tx_data});
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    div_lat = 3;
    run_one(8'h08, 8'h0D, "basic");
    checks++;
    if (starts !== 1) begin
      errors++;
      $display("FAIL basic_starts: got %0d, need 1", starts);
    end
    clear_env();
  endtask

  task automatic test_tx_full();
    div_lat = 4;
    full_after_done = 5;
    run_one(8'hC8, 8'h07, "txfull");
    checks++;
    if (tx_cyc.size() < 1 || tx_cyc[0] != done_cyc + 6) begin
      errors++;
      $display("FAIL txfull_timing: got push at %0d, need %0d",
               (tx_cyc.size() != 0) ? tx_cyc[0] : -1, done_cyc + 6);
    end
    full_after_done = 0;
    clear_env();
  endtask

  task automatic test_div0();
    run_one(8'h37, 8'h00, "div0");
    checks++;
    if (starts !== 0) begin
      errors++;
      $display("FAIL div0_starts: got %0d, need 0", starts);
    end
    checks++;
    if (tx_cyc.size() < 1 || rd_cyc.size() < 2 || tx_cyc[0] != rd_cyc[1] + 2) begin
      errors++;
      $display("FAIL div0_timing: got push at %0d, need %0d",
               (tx_cyc.size() != 0) ? tx_cyc[0] : -1,
               (rd_cyc.size() > 1) ? rd_cyc[1] + 2 : -1);
    end
    clear_env();
  endtask

  task automatic test_timeout();
    div_lat = 0;
    run_one(8'h50, 8'h05, "hang");
    checks++;
    if (tx_cyc.size() < 1 || tx_cyc[0] - start_cyc != TO + 1) begin
      errors++;
      $display("FAIL hang_timing: got %0d, need %0d",
               (tx_cyc.size() != 0) ? tx_cyc[0] - start_cyc : -1, TO + 1);
    end
    clear_env();
    div_lat = TO;
    run_one(8'h50, 8'h05, "done_at_expiry");
    clear_env();
    div_lat = TO + 1;
    run_one(8'h51, 8'h05, "done_after_expiry");
    clear_env();
  endtask

  task automatic test_rx_gaps();
    int k = 0;
    div_lat = 2;
    rx_hold_rand = 1;
    rxq.push_back(8'h64);
    while (!busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    stray_done = 1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (!busy || txq.size() != 0) begin
      errors++;
      $display("FAIL stray_done: got busy=%b bytes=%0d, need busy=1 bytes=0",
               busy, txq.size());
    end
    run_one_y(8'h64, 8'h09);
    rx_hold_rand = 0;
    clear_env();
  endtask

  task automatic run_one_y(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er;
    bit ok;
    ref_reply(a, b, div_lat, eq, er);
    rxq.push_back(b);
    wait_tx(2, ok);
    checks++;
    if (!ok || txq[0] !== eq || txq[1] !== er || starts !== 1) begin
      errors++;
      $display("FAIL rx_gaps: got %02h %02h starts=%0d, need %02h %02h starts=1",
               ok ? txq[0] : 8'h0, ok ? txq[1] : 8'h0, starts, eq, er);
    end
  endtask

  task automatic test_reset_mid();
    div_lat = 0;
    rxq.push_back(8'h40);
    rxq.push_back(8'h02);
    repeat (8) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({rd_uart, wr_uart, start, busy, x, y, tx_data} !== 28'h0) begin
      errors++;
      $display("FAIL reset_mid: got %b %02h %02h %02h, need all zero",
               {rd_uart, wr_uart, start, busy}, x, y, tx_data);
    end
    rxq.delete();
    div_pend = 0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    clear_env();
    repeat (5) @(negedge clk);
    checks++;
    if (txq.size() != 0) begin
      errors++;
      $display("FAIL reset_discard: got %0d bytes, need 0", txq.size());
    end
    div_lat = 2;
    run_one(8'h09, 8'h03, "after_reset");
    clear_env();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    logic [7:0] eq, er, a, b;
    int nstart = 0;
    int lat, sel, bad = 0;
    bit ok;
    tx_full_rand = 1;
    rx_hold_rand = 1;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      if ($urandom_range(0, 5) == 0) b = 8'h00;
      else if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(1, 15));
      else b = 8'($urandom_range(1, 255));
      sel = $urandom_range(0, 7);
      lat = (sel == 0) ? 0 : (sel == 1) ? TO : (sel == 2) ? TO + 1 :
            (sel == 3) ? TO + 4 : $urandom_range(1, 12);
      if (b != 0) begin
        lat_q.push_back(lat);
        nstart++;
      end
      ref_reply(a, b, lat, eq, er);
      exp.push_back(eq);
      exp.push_back(er);
      rxq.push_back(a);
      rxq.push_back(b);
    end
    wait_tx(48, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b timeout: got %0d bytes, need 48", txq.size());
    end else begin
      for (int i = 0; i < 48; i++) begin
        checks++;
        if (txq[i] !== exp[i]) begin
          errors++;
          $display("FAIL b2b byte %0d: got %02h, need %02h", i, txq[i], exp[i]);
        end
      end
      for (int k = 1; k < 24; k++)
        if (rd_cyc[2*k] <= tx_cyc[2*k-1]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL b2b_overlap: got %0d early pops, need 0", bad);
      end
    end
    checks++;
    if (starts !== nstart) begin
      errors++;
      $display("FAIL b2b_starts: got %0d, need %0d", starts, nstart);
    end
    tx_full_rand = 0;
    rx_hold_rand = 0;
    clear_env();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tx_full();
    test_div0();
    test_timeout();
    test_rx_gaps();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (proto_err !== 0) begin
      errors++;
      $display("FAIL protocol: got %0d violations, need 0", proto_err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
